exception_commit_unit: RTL and testbench
========================================

Name: exception_commit_unit

Overview:
Writeback-stage exception and CP0-access commit logic. It prioritises exceptions and interrupts for the instruction in WB and drives the write-side bus into coprocessor0: writes, exception_valid, eret_flush, exception code and EPC/BadVAddr sources. It consumes CP0's interrupt_valid and EPC and emits a one-cycle kill pulse to younger stages. It then holds a registered redirect request to IF until IF accepts it.

Parameters:
EXC_VECTOR, 32'hBFC0_0380, PC redirected to on any exception or interrupt
DATA_WIDTH, 32, width of PC, data and address buses

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high
wb_valid  in  1  instruction present in WB this cycle
wb_pc  in  32  PC of WB instruction
wb_in_delay_slot  in  1  WB instruction is in a branch delay slot
wb_exc_flags  in  7  {adel_fetch, ri, ov, syscall, break, adel_load, ades}, bit6..bit0
wb_badvaddr  in  32  faulting data address (load/store faults)
wb_is_mtc0 / wb_is_mfc0 / wb_is_eret  in  1 each  instruction class
wb_cp0_reg  in  5  CP0 register number
wb_cp0_sel  in  3  CP0 select
wb_rt_value  in  32  mtc0 source data
cp0_interrupt_valid  in  8  masked pending interrupts from CP0
cp0_epc  in  32  current EPC from CP0
if_redirect_ready  in  1  IF accepts redirect
cp0_write_enabled, cp0_address_register[5], cp0_address_select[3], cp0_write_data[32]  out  CP0 access
cp0_exception_valid, cp0_eret_flush, cp0_exception_code[5], cp0_exception_address[32], cp0_in_delay_slot, cp0_is_address_fault, cp0_badvaddr_value[32]  out  CP0 exception bus
wb_commit  out  1  WB instruction retires (regfile write allowed)
flush_pulse  out  1  combinational kill of IF/ID/EX/MEM this cycle
redirect_valid  out  1  registered redirect request to IF
redirect_pc  out  32  registered redirect target

Behaviour:
- States: IDLE, REDIRECT. Reset: IDLE, redirect_valid=0, redirect_pc=0, int_pending_q=0. All combinational outputs are 0 when wb_valid=0 or state=REDIRECT.
- int_pending_q <= |cp0_interrupt_valid every cycle. An interrupt is taken when state=IDLE & wb_valid & int_pending_q & |cp0_interrupt_valid.
- Priority, highest first, with exception codes:
  - interrupt: 0
  - adel_fetch: 4
  - ri: 10
  - ov: 12
  - syscall: 8
  - break: 9
  - adel_load: 4
  - ades: 5
- exc = taken interrupt or any flag. Only in IDLE & wb_valid.
- On exc:
  - cp0_exception_valid=1 and cp0_exception_code per priority.
  - cp0_exception_address=wb_pc; cp0_in_delay_slot=wb_in_delay_slot.
  - cp0_is_address_fault=1 for adel/ades codes, but not when an interrupt won.
  - cp0_badvaddr_value=wb_pc for adel_fetch, else wb_badvaddr.
  - cp0_write_enabled=0 and wb_commit=0.
  - flush_pulse=1; next: state=REDIRECT, redirect_pc=EXC_VECTOR.
- eret without exc: cp0_eret_flush=1, wb_commit=1, flush_pulse=1; next: REDIRECT, redirect_pc=cp0_epc sampled this cycle.
- mtc0 without exc: cp0_write_enabled=1, address=wb_cp0_reg/wb_cp0_sel, write_data=wb_rt_value, wb_commit=1.
- mfc0 without exc: address driven, write_enabled=0, wb_commit=1.
- Other valid instruction without exc: wb_commit=1.
- REDIRECT state:
  - redirect_valid=1, redirect_pc held stable.
  - All WB instructions squashed: wb_commit=0, no CP0 side effects, no new exception detection.
  - On if_redirect_ready=1, next cycle is IDLE with redirect_valid=0. Minimum redirect_valid length is 1 cycle.
- Reset in REDIRECT: IDLE next cycle, redirect dropped.
- Latency: CP0 bus and flush_pulse are combinational, same cycle as WB. redirect_valid rises at T+1.

Test Plan:
- ADD in WB with ov=1, pc=0x8000_0100 -> T: exception_valid=1, code=12, exception_address=0x8000_0100, wb_commit=0, flush_pulse=1. T+1: redirect_valid=1, redirect_pc=0xBFC0_0380.
- LW fault, badvaddr=0x0000_0003, in_delay_slot=1 -> code=4, is_address_fault=1, badvaddr_value=0x3, in_delay_slot=1. Then set adel_fetch+ri together -> code=4, badvaddr_value=wb_pc.
- cp0_interrupt_valid=0x80 for 2 cycles, then valid syscall in WB -> code=0 (interrupt beats syscall), is_address_fault=0. Interrupt high only 1 cycle before WB -> no interrupt taken, code=8.
- eret with cp0_epc=0x8000_0200 -> eret_flush=1, exception_valid=0. T+1: redirect_pc=0x8000_0200. Hold if_redirect_ready=0 for 3 cycles -> redirect_valid stays 1 and WB mtc0s are squashed (write_enabled=0). Ready=1 -> IDLE next cycle.
- mtc0 reg 12 sel 0 data 0x0000_FF01 -> write_enabled=1, address_register=12, address_select=0, write_data=0x0000_FF01, wb_commit=1. Same mtc0 with ri=1 -> write_enabled=0.
- reset asserted while REDIRECT -> next cycle redirect_valid=0, state IDLE, int_pending_q=0.

Source files
------------

// File: rtl/exception_commit_unit.sv
// ---------------------------------------------------------------------------
// ExceptionCommitUnit (top: exception_commit_unit)
//
// Writeback-stage exception and CP0-access commit logic. For the instruction
// sitting in WB it picks the highest-priority exception or interrupt, drives
// the write side of coprocessor0 (mtc0 writes, exception bus, eret flush),
// decides whether the instruction retires, and kills all younger stages with
// a one-cycle combinational flush pulse. After a flush it holds a registered
// redirect request towards IF until IF accepts it.
//
// Ports:
//   clock, reset              clock and synchronous active-high reset
//   wb_valid                  an instruction is present in WB
//   wb_pc, wb_in_delay_slot   PC of the WB instruction and delay-slot flag
//   wb_exc_flags[6:0]         {adel_fetch, ri, ov, syscall, break, adel_load, ades}
//   wb_badvaddr               faulting data address for load/store faults
//   wb_is_mtc0/mfc0/eret      instruction class
//   wb_cp0_reg, wb_cp0_sel    CP0 register number and select
//   wb_rt_value               mtc0 source data
//   cp0_interrupt_valid       masked pending interrupts reported by CP0
//   cp0_epc                   current EPC held in CP0
//   if_redirect_ready         IF accepts the redirect request
//   cp0_*                     CP0 access and exception bus (combinational)
//   wb_commit                 WB instruction retires
//   flush_pulse               combinational kill of IF/ID/EX/MEM
//   redirect_valid/_pc        registered redirect request and target to IF
// ---------------------------------------------------------------------------
module exception_commit_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wb_valid,
    input  logic [DATA_WIDTH-1:0] wb_pc,
    input  logic                  wb_in_delay_slot,
    input  logic [6:0]            wb_exc_flags,
    input  logic [DATA_WIDTH-1:0] wb_badvaddr,
    input  logic                  wb_is_mtc0,
    input  logic                  wb_is_mfc0,
    input  logic                  wb_is_eret,
    input  logic [4:0]            wb_cp0_reg,
    input  logic [2:0]            wb_cp0_sel,
    input  logic [DATA_WIDTH-1:0] wb_rt_value,
    input  logic [7:0]            cp0_interrupt_valid,
    input  logic [DATA_WIDTH-1:0] cp0_epc,
    input  logic                  if_redirect_ready,
    output logic                  cp0_write_enabled,
    output logic [4:0]            cp0_address_register,
    output logic [2:0]            cp0_address_select,
    output logic [DATA_WIDTH-1:0] cp0_write_data,
    output logic                  cp0_exception_valid,
    output logic                  cp0_eret_flush,
    output logic [4:0]            cp0_exception_code,
    output logic [DATA_WIDTH-1:0] cp0_exception_address,
    output logic                  cp0_in_delay_slot,
    output logic                  cp0_is_address_fault,
    output logic [DATA_WIDTH-1:0] cp0_badvaddr_value,
    output logic                  wb_commit,
    output logic                  flush_pulse,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc
);

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef enum logic {
        IDLE,
        REDIRECT
    } state_t;

    state_t                  state_q;
    logic                    int_pending_q;
    logic                    redirect_valid_q;
    logic [DATA_WIDTH-1:0]   redirect_pc_q;

    logic                    wbActive;
    logic                    intTaken;
    logic                    excTaken;
    logic                    eretTaken;
    logic [4:0]              excCode;
    logic                    addrFault;
    logic                    useFetchAddr;

    // WB is only looked at while no redirect is outstanding; everything in WB
    // during REDIRECT is wrong-path and is squashed without side effects.
    // An interrupt must have been pending for a full cycle (int_pending_q)
    // and still be pending now, which filters one-cycle glitches from CP0.
    assign wbActive  = (state_q == IDLE) && wb_valid;
    assign intTaken  = wbActive && int_pending_q && (|cp0_interrupt_valid);
    assign excTaken  = intTaken || (wbActive && (|wb_exc_flags));
    assign eretTaken = wbActive && !excTaken && wb_is_eret;

    // Priority encoder for the exception cause. Only the winning cause
    // decides whether this counts as an address fault and which address is
    // reported as BadVAddr (fetch faults report the PC itself).
    always_comb begin
        excCode      = EXC_INT;
        addrFault    = 1'b0;
        useFetchAddr = 1'b0;
        if (intTaken) begin
            excCode = EXC_INT;
        end else if (wb_exc_flags[6]) begin
            excCode      = EXC_ADEL;
            addrFault    = 1'b1;
            useFetchAddr = 1'b1;
        end else if (wb_exc_flags[5]) begin
            excCode = EXC_RI;
        end else if (wb_exc_flags[4]) begin
            excCode = EXC_OV;
        end else if (wb_exc_flags[3]) begin
            excCode = EXC_SYS;
        end else if (wb_exc_flags[2]) begin
            excCode = EXC_BP;
        end else if (wb_exc_flags[1]) begin
            excCode   = EXC_ADEL;
            addrFault = 1'b1;
        end else if (wb_exc_flags[0]) begin
            excCode   = EXC_ADES;
            addrFault = 1'b1;
        end
    end

    // CP0 bus, commit and flush. All of it stays at zero unless an
    // instruction is live in WB while idle. An exception suppresses the
    // instruction's own CP0 access and its retirement.
    always_comb begin
        cp0_write_enabled     = 1'b0;
        cp0_address_register  = '0;
        cp0_address_select    = '0;
        cp0_write_data        = '0;
        cp0_exception_valid   = 1'b0;
        cp0_eret_flush        = 1'b0;
        cp0_exception_code    = '0;
        cp0_exception_address = '0;
        cp0_in_delay_slot     = 1'b0;
        cp0_is_address_fault  = 1'b0;
        cp0_badvaddr_value    = '0;
        wb_commit             = 1'b0;
        flush_pulse           = 1'b0;
        if (excTaken) begin
            cp0_exception_valid   = 1'b1;
            cp0_exception_code    = excCode;
            cp0_exception_address = wb_pc;
            cp0_in_delay_slot     = wb_in_delay_slot;
            cp0_is_address_fault  = addrFault;
            cp0_badvaddr_value    = useFetchAddr ? wb_pc : wb_badvaddr;
            flush_pulse           = 1'b1;
        end else if (wbActive) begin
            wb_commit = 1'b1;
            if (eretTaken) begin
                cp0_eret_flush = 1'b1;
                flush_pulse    = 1'b1;
            end
            if (wb_is_mtc0) begin
                cp0_write_enabled    = 1'b1;
                cp0_address_register = wb_cp0_reg;
                cp0_address_select   = wb_cp0_sel;
                cp0_write_data       = wb_rt_value;
            end else if (wb_is_mfc0) begin
                cp0_address_register = wb_cp0_reg;
                cp0_address_select   = wb_cp0_sel;
            end
        end
    end

    // Redirect FSM. A flush in IDLE latches the target (exception vector or
    // the EPC seen this cycle) and raises redirect_valid next cycle; the
    // request and target are held until IF signals ready.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= IDLE;
            int_pending_q    <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            int_pending_q <= |cp0_interrupt_valid;
            case (state_q)
                IDLE: begin
                    if (excTaken) begin
                        state_q          <= REDIRECT;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= EXC_VECTOR;
                    end else if (eretTaken) begin
                        state_q          <= REDIRECT;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= cp0_epc;
                    end
                end
                REDIRECT: begin
                    if (if_redirect_ready) begin
                        state_q          <= IDLE;
                        redirect_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q          <= IDLE;
                    redirect_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_exception_commit_unit.sv
// ---------------------------------------------------------------------------
// Testbench for exception_commit_unit. A table of directed WB vectors with
// hand-computed expected CP0-bus / commit / flush / redirect results, plus
// hand-written sequences for interrupt qualification, redirect hold with
// squashing, and reset while a redirect is outstanding.
// ---------------------------------------------------------------------------
module tb_exception_commit_unit;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clock;
    logic        reset;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        wb_in_delay_slot;
    logic [6:0]  wb_exc_flags;
    logic [31:0] wb_badvaddr;
    logic        wb_is_mtc0;
    logic        wb_is_mfc0;
    logic        wb_is_eret;
    logic [4:0]  wb_cp0_reg;
    logic [2:0]  wb_cp0_sel;
    logic [31:0] wb_rt_value;
    logic [7:0]  cp0_interrupt_valid;
    logic [31:0] cp0_epc;
    logic        if_redirect_ready;
    logic        cp0_write_enabled;
    logic [4:0]  cp0_address_register;
    logic [2:0]  cp0_address_select;
    logic [31:0] cp0_write_data;
    logic        cp0_exception_valid;
    logic        cp0_eret_flush;
    logic [4:0]  cp0_exception_code;
    logic [31:0] cp0_exception_address;
    logic        cp0_in_delay_slot;
    logic        cp0_is_address_fault;
    logic [31:0] cp0_badvaddr_value;
    logic        wb_commit;
    logic        flush_pulse;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    exception_commit_unit dut (
        .clock                 (clock),
        .reset                 (reset),
        .wb_valid              (wb_valid),
        .wb_pc                 (wb_pc),
        .wb_in_delay_slot      (wb_in_delay_slot),
        .wb_exc_flags          (wb_exc_flags),
        .wb_badvaddr           (wb_badvaddr),
        .wb_is_mtc0            (wb_is_mtc0),
        .wb_is_mfc0            (wb_is_mfc0),
        .wb_is_eret            (wb_is_eret),
        .wb_cp0_reg            (wb_cp0_reg),
        .wb_cp0_sel            (wb_cp0_sel),
        .wb_rt_value           (wb_rt_value),
        .cp0_interrupt_valid   (cp0_interrupt_valid),
        .cp0_epc               (cp0_epc),
        .if_redirect_ready     (if_redirect_ready),
        .cp0_write_enabled     (cp0_write_enabled),
        .cp0_address_register  (cp0_address_register),
        .cp0_address_select    (cp0_address_select),
        .cp0_write_data        (cp0_write_data),
        .cp0_exception_valid   (cp0_exception_valid),
        .cp0_eret_flush        (cp0_eret_flush),
        .cp0_exception_code    (cp0_exception_code),
        .cp0_exception_address (cp0_exception_address),
        .cp0_in_delay_slot     (cp0_in_delay_slot),
        .cp0_is_address_fault  (cp0_is_address_fault),
        .cp0_badvaddr_value    (cp0_badvaddr_value),
        .wb_commit             (wb_commit),
        .flush_pulse           (flush_pulse),
        .redirect_valid        (redirect_valid),
        .redirect_pc           (redirect_pc)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        ds;
        logic [6:0]  flags;
        logic [31:0] badvaddr;
        logic        mtc0;
        logic        mfc0;
        logic        eret;
        logic [4:0]  cpReg;
        logic [2:0]  cpSel;
        logic [31:0] rt;
        logic [7:0]  irq;
        logic [31:0] epc;
        logic        expExc;
        logic [4:0]  expCode;
        logic        expEret;
        logic        expWe;
        logic        expCommit;
        logic        expFlush;
        logic        expFault;
        logic [31:0] expBadv;
        logic [4:0]  expAreg;
        logic [2:0]  expAsel;
        logic [31:0] expWdata;
        logic [31:0] expRpc;
    } vec_t;

    vec_t vecs[$];
    vec_t v;
    int   checks;
    int   failures;

    task automatic checkVal(input string name, input int idx,
                            input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s (case %0d): got 0x%0h, expected 0x%0h",
                     name, idx, act, exp);
        end
    endtask

    task automatic clearInputs();
        wb_valid            = 1'b0;
        wb_pc               = '0;
        wb_in_delay_slot    = 1'b0;
        wb_exc_flags        = '0;
        wb_badvaddr         = '0;
        wb_is_mtc0          = 1'b0;
        wb_is_mfc0          = 1'b0;
        wb_is_eret          = 1'b0;
        wb_cp0_reg          = '0;
        wb_cp0_sel          = '0;
        wb_rt_value         = '0;
        cp0_interrupt_valid = '0;
        cp0_epc             = '0;
    endtask

    task automatic applyStimulus(input vec_t s);
        wb_valid            = s.valid;
        wb_pc               = s.pc;
        wb_in_delay_slot    = s.ds;
        wb_exc_flags        = s.flags;
        wb_badvaddr         = s.badvaddr;
        wb_is_mtc0          = s.mtc0;
        wb_is_mfc0          = s.mfc0;
        wb_is_eret          = s.eret;
        wb_cp0_reg          = s.cpReg;
        wb_cp0_sel          = s.cpSel;
        wb_rt_value         = s.rt;
        cp0_interrupt_valid = s.irq;
        cp0_epc             = s.epc;
    endtask

    task automatic checkOutput(input vec_t s, input int idx);
        checkVal("exception_valid", idx, 32'(cp0_exception_valid), 32'(s.expExc));
        checkVal("exception_code",  idx, 32'(cp0_exception_code),  32'(s.expCode));
        checkVal("eret_flush",      idx, 32'(cp0_eret_flush),      32'(s.expEret));
        checkVal("write_enabled",   idx, 32'(cp0_write_enabled),   32'(s.expWe));
        checkVal("wb_commit",       idx, 32'(wb_commit),           32'(s.expCommit));
        checkVal("flush_pulse",     idx, 32'(flush_pulse),         32'(s.expFlush));
        if (s.expExc) begin
            checkVal("exception_address", idx, cp0_exception_address, s.pc);
            checkVal("in_delay_slot",     idx, 32'(cp0_in_delay_slot), 32'(s.ds));
            checkVal("is_address_fault",  idx, 32'(cp0_is_address_fault), 32'(s.expFault));
            checkVal("badvaddr_value",    idx, cp0_badvaddr_value, s.expBadv);
        end else begin
            checkVal("address_register", idx, 32'(cp0_address_register), 32'(s.expAreg));
            checkVal("address_select",   idx, 32'(cp0_address_select),   32'(s.expAsel));
            if (s.expWe)
                checkVal("write_data", idx, cp0_write_data, s.expWdata);
        end
    endtask

    // Drive one WB vector on a falling edge and check combinational outputs.
    task automatic applyAndCheck(input vec_t s, input int idx);
        @(negedge clock);
        applyStimulus(s);
        #2;
        checkOutput(s, idx);
    endtask

    // After a flushing cycle: redirect must be up with the right target,
    // then IF accepts it and the request drops on the following cycle.
    task automatic followRedirect(input logic [31:0] rpc, input int idx);
        @(negedge clock);
        clearInputs();
        #2;
        checkVal("redirect_valid_up", idx, 32'(redirect_valid), 32'd1);
        checkVal("redirect_pc",       idx, redirect_pc, rpc);
        if_redirect_ready = 1'b1;
        @(negedge clock);
        if_redirect_ready = 1'b0;
        #2;
        checkVal("redirect_valid_down", idx, 32'(redirect_valid), 32'd0);
    endtask

    task automatic runVector(input vec_t s, input int idx);
        applyAndCheck(s, idx);
        if (s.expFlush) begin
            followRedirect(s.expRpc, idx);
        end else begin
            @(negedge clock);
            clearInputs();
            #2;
            checkVal("redirect_valid_idle", idx, 32'(redirect_valid), 32'd0);
        end
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        if_redirect_ready = 1'b0;
        clearInputs();
        reset = 1'b1;

        // ---------------- table of directed WB vectors -------------------
        // 0: ADD overflow
        v = '0; v.valid = 1; v.pc = 32'h8000_0100; v.flags = 7'b0010000;
        v.expExc = 1; v.expCode = 5'd12; v.expFlush = 1; v.expBadv = 32'h0;
        v.expRpc = VEC; vecs.push_back(v);
        // 1: LW address fault in delay slot
        v = '0; v.valid = 1; v.pc = 32'h8000_0200; v.ds = 1; v.flags = 7'b0000010;
        v.badvaddr = 32'h0000_0003;
        v.expExc = 1; v.expCode = 5'd4; v.expFlush = 1; v.expFault = 1;
        v.expBadv = 32'h0000_0003; v.expRpc = VEC; vecs.push_back(v);
        // 2: fetch fault + RI: fetch fault wins, BadVAddr is the PC
        v = '0; v.valid = 1; v.pc = 32'h8000_0300; v.flags = 7'b1100000;
        v.badvaddr = 32'h0000_1234;
        v.expExc = 1; v.expCode = 5'd4; v.expFlush = 1; v.expFault = 1;
        v.expBadv = 32'h8000_0300; v.expRpc = VEC; vecs.push_back(v);
        // 3: store address fault
        v = '0; v.valid = 1; v.pc = 32'h8000_0304; v.flags = 7'b0000001;
        v.badvaddr = 32'h0000_0010;
        v.expExc = 1; v.expCode = 5'd5; v.expFlush = 1; v.expFault = 1;
        v.expBadv = 32'h0000_0010; v.expRpc = VEC; vecs.push_back(v);
        // 4: syscall + break: syscall wins
        v = '0; v.valid = 1; v.pc = 32'h8000_0308; v.flags = 7'b0001100;
        v.expExc = 1; v.expCode = 5'd8; v.expFlush = 1; v.expRpc = VEC;
        vecs.push_back(v);
        // 5: break alone
        v = '0; v.valid = 1; v.pc = 32'h8000_030C; v.flags = 7'b0000100;
        v.expExc = 1; v.expCode = 5'd9; v.expFlush = 1; v.expRpc = VEC;
        vecs.push_back(v);
        // 6: RI beats load fault, so not an address fault
        v = '0; v.valid = 1; v.pc = 32'h8000_0310; v.flags = 7'b0100010;
        v.badvaddr = 32'h0000_0044;
        v.expExc = 1; v.expCode = 5'd10; v.expFlush = 1; v.expFault = 0;
        v.expBadv = 32'h0000_0044; v.expRpc = VEC; vecs.push_back(v);
        // 7: eret
        v = '0; v.valid = 1; v.pc = 32'h8000_0314; v.eret = 1; v.epc = 32'h8000_0200;
        v.expEret = 1; v.expCommit = 1; v.expFlush = 1; v.expRpc = 32'h8000_0200;
        vecs.push_back(v);
        // 8: mtc0 reg 12 sel 0
        v = '0; v.valid = 1; v.pc = 32'h8000_0318; v.mtc0 = 1; v.cpReg = 5'd12;
        v.rt = 32'h0000_FF01;
        v.expWe = 1; v.expCommit = 1; v.expAreg = 5'd12; v.expWdata = 32'h0000_FF01;
        vecs.push_back(v);
        // 9: same mtc0 with RI: no write, exception instead
        v = '0; v.valid = 1; v.pc = 32'h8000_0318; v.mtc0 = 1; v.cpReg = 5'd12;
        v.rt = 32'h0000_FF01; v.flags = 7'b0100000;
        v.expExc = 1; v.expCode = 5'd10; v.expFlush = 1; v.expRpc = VEC;
        vecs.push_back(v);
        // 10: mfc0 reg 14 sel 0
        v = '0; v.valid = 1; v.pc = 32'h8000_031C; v.mfc0 = 1; v.cpReg = 5'd14;
        v.expCommit = 1; v.expAreg = 5'd14; vecs.push_back(v);
        // 11: plain instruction
        v = '0; v.valid = 1; v.pc = 32'h8000_0320; v.expCommit = 1; vecs.push_back(v);
        // 12: bubble carrying junk flags: everything quiet
        v = '0; v.valid = 0; v.pc = 32'h8000_0324; v.flags = 7'b1111111; v.mtc0 = 1;
        v.cpReg = 5'd3; vecs.push_back(v);
        // 13: eret with overflow: exception wins, no eret flush
        v = '0; v.valid = 1; v.pc = 32'h8000_0328; v.eret = 1; v.flags = 7'b0010000;
        v.epc = 32'h8000_0500;
        v.expExc = 1; v.expCode = 5'd12; v.expFlush = 1; v.expRpc = VEC;
        vecs.push_back(v);
        // 14: mtc0 reg 9 sel 3
        v = '0; v.valid = 1; v.pc = 32'h8000_032C; v.mtc0 = 1; v.cpReg = 5'd9;
        v.cpSel = 3'd3; v.rt = 32'hCAFE_0001;
        v.expWe = 1; v.expCommit = 1; v.expAreg = 5'd9; v.expAsel = 3'd3;
        v.expWdata = 32'hCAFE_0001; vecs.push_back(v);

        // ---------------- reset state -------------------------------------
        repeat (2) @(negedge clock);
        #2;
        checkVal("reset_redirect_valid", 0, 32'(redirect_valid), 32'd0);
        checkVal("reset_redirect_pc",    0, redirect_pc, 32'h0);
        checkVal("reset_commit",         0, 32'(wb_commit), 32'd0);
        checkVal("reset_flush",          0, 32'(flush_pulse), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            runVector(vecs[i], i);

        // ---------------- interrupt held two cycles beats syscall --------
        @(negedge clock);
        clearInputs();
        cp0_interrupt_valid = 8'h80;
        v = '0; v.valid = 1; v.pc = 32'h8000_0400; v.flags = 7'b0001000; v.irq = 8'h80;
        v.expExc = 1; v.expCode = 5'd0; v.expFlush = 1; v.expFault = 0; v.expRpc = VEC;
        applyAndCheck(v, 100);
        followRedirect(VEC, 100);

        // interrupt beats a load fault and is not an address fault
        @(negedge clock);
        clearInputs();
        cp0_interrupt_valid = 8'h80;
        v = '0; v.valid = 1; v.pc = 32'h8000_0404; v.flags = 7'b0000010; v.irq = 8'h80;
        v.badvaddr = 32'h0000_0055;
        v.expExc = 1; v.expCode = 5'd0; v.expFlush = 1; v.expFault = 0;
        v.expBadv = 32'h0000_0055; v.expRpc = VEC;
        applyAndCheck(v, 101);
        followRedirect(VEC, 101);

        // interrupt only in the cycle before WB: not taken
        @(negedge clock);
        clearInputs();
        cp0_interrupt_valid = 8'h80;
        v = '0; v.valid = 1; v.pc = 32'h8000_0408; v.flags = 7'b0001000; v.irq = 8'h00;
        v.expExc = 1; v.expCode = 5'd8; v.expFlush = 1; v.expRpc = VEC;
        applyAndCheck(v, 102);
        followRedirect(VEC, 102);

        // interrupt first appears in the WB cycle: not yet taken
        @(negedge clock);
        clearInputs();
        v = '0; v.valid = 1; v.pc = 32'h8000_040C; v.flags = 7'b0001000; v.irq = 8'h80;
        v.expExc = 1; v.expCode = 5'd8; v.expFlush = 1; v.expRpc = VEC;
        applyAndCheck(v, 103);
        followRedirect(VEC, 103);

        // ---------------- eret, redirect held while IF stalls -------------
        v = '0; v.valid = 1; v.pc = 32'h8000_0500; v.eret = 1; v.epc = 32'h8000_0200;
        v.expEret = 1; v.expCommit = 1; v.expFlush = 1;
        applyAndCheck(v, 110);
        for (int i = 0; i < 3; i++) begin
            v = '0; v.valid = 1; v.pc = 32'h8000_0504 + 32'(i * 4); v.mtc0 = 1;
            v.cpReg = 5'd12; v.rt = 32'h1111_0000; v.epc = 32'hDEAD_0000;
            v.flags = (i == 1) ? 7'b0010000 : 7'b0000000;
            applyAndCheck(v, 111 + i);
            checkVal("hold_redirect_valid", 111 + i, 32'(redirect_valid), 32'd1);
            checkVal("hold_redirect_pc",    111 + i, redirect_pc, 32'h8000_0200);
        end
        @(negedge clock);
        clearInputs();
        if_redirect_ready = 1'b1;
        #2;
        checkVal("ready_cycle_valid", 114, 32'(redirect_valid), 32'd1);
        @(negedge clock);
        if_redirect_ready = 1'b0;
        #2;
        checkVal("after_ready_valid", 115, 32'(redirect_valid), 32'd0);
        v = '0; v.valid = 1; v.pc = 32'h8000_0600; v.mtc0 = 1; v.cpReg = 5'd12;
        v.rt = 32'h0000_FF01;
        v.expWe = 1; v.expCommit = 1; v.expAreg = 5'd12; v.expWdata = 32'h0000_FF01;
        runVector(v, 116);

        // ---------------- reset while a redirect is outstanding ----------
        v = '0; v.valid = 1; v.pc = 32'h8000_0700; v.flags = 7'b0010000;
        v.expExc = 1; v.expCode = 5'd12; v.expFlush = 1; v.expRpc = VEC;
        applyAndCheck(v, 120);
        @(negedge clock);
        clearInputs();
        #2;
        checkVal("pre_reset_valid", 120, 32'(redirect_valid), 32'd1);
        reset = 1'b1;
        cp0_interrupt_valid = 8'h80;
        @(negedge clock);
        reset = 1'b0;
        v = '0; v.valid = 1; v.pc = 32'h8000_0704; v.flags = 7'b0001000; v.irq = 8'h80;
        v.expExc = 1; v.expCode = 5'd8; v.expFlush = 1; v.expRpc = VEC;
        applyStimulus(v);
        #2;
        checkVal("post_reset_valid", 121, 32'(redirect_valid), 32'd0);
        checkVal("post_reset_pc",    121, redirect_pc, 32'h0);
        checkOutput(v, 121);
        followRedirect(VEC, 121);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
